// File: rtl/blob_box_controller.sv
// Motion-blob bounding-box controller: accumulates the box of qualifying motion
// pixels across a frame and hands the latched box/centre downstream via valid/ready.
module blob_box_controller #(
  parameter int X_LIMIT    = 319,
  parameter int Y_LIMIT    = 239,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 17
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iFrameStart,
  input  logic             iFrameEnd,
  input  logic             iPixelValid,
  input  logic             iMotion,
  input  logic [8:0]       iX,
  input  logic [7:0]       iY,
  input  logic             iReady,
  output logic             oNewCoord,
  output logic             oBoxValid,
  output logic [8:0]       oXmin,
  output logic [8:0]       oXmax,
  output logic [7:0]       oYmin,
  output logic [7:0]       oYmax,
  output logic [8:0]       oXcenter,
  output logic [7:0]       oYcenter,
  output logic [CNT_W-1:0] oPixCount
);

  // state  | meaning
  // IDLE   | waiting for a frame start
  // ACCUM  | folding qualifying pixels into the running box
  // CENTER | one cycle: snapshot box, centre and count into the result stage
  // OUTPUT | result presented; waits for iReady
  typedef enum logic [1:0] {IDLE, ACCUM, CENTER, OUTPUT} stateT;

  stateT state, stateNext;

  logic [8:0]       xMinRun, xMaxRun;
  logic [7:0]       yMinRun, yMaxRun;
  logic [CNT_W-1:0] pixCnt;

  logic [8:0]       resXmin, resXmax, resXcenter;
  logic [7:0]       resYmin, resYmax, resYcenter;
  logic [CNT_W-1:0] resCnt;
  logic             resValid;

  logic clearRun, accumEn, latchRes, publish, accept;
  logic qualify, boxOk;
  logic [9:0] xSum;
  logic [8:0] ySum;

  assign qualify = iPixelValid && iMotion && (iX <= 9'(X_LIMIT)) && (iY <= 8'(Y_LIMIT));
  assign boxOk   = (pixCnt >= CNT_W'(MIN_PIXELS));
  assign xSum    = {1'b0, xMinRun} + {1'b0, xMaxRun};
  assign ySum    = {1'b0, yMinRun} + {1'b0, yMaxRun};

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    clearRun  = 1'b0;
    accumEn   = 1'b0;
    latchRes  = 1'b0;
    publish   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (iFrameStart) begin
          clearRun  = 1'b1;
          stateNext = ACCUM;
        end
      end
      ACCUM: begin
        accumEn = qualify;
        if (iFrameEnd) begin
          stateNext = CENTER;
        end else if (iFrameStart) begin
          clearRun = 1'b1;
          accumEn  = 1'b0;
        end
      end
      CENTER: begin
        latchRes  = 1'b1;
        stateNext = OUTPUT;
      end
      OUTPUT: begin
        // First OUTPUT cycle publishes the result stage; later cycles wait for iReady.
        if (!oNewCoord) begin
          publish = 1'b1;
        end else if (iReady) begin
          accept    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      xMinRun <= '1;
      xMaxRun <= '0;
      yMinRun <= '1;
      yMaxRun <= '0;
      pixCnt  <= '0;
    end else if (clearRun) begin
      xMinRun <= '1;
      xMaxRun <= '0;
      yMinRun <= '1;
      yMaxRun <= '0;
      pixCnt  <= '0;
    end else if (accumEn) begin
      if (iX < xMinRun) xMinRun <= iX;
      if (iX > xMaxRun) xMaxRun <= iX;
      if (iY < yMinRun) yMinRun <= iY;
      if (iY > yMaxRun) yMaxRun <= iY;
      if (pixCnt != '1) pixCnt <= pixCnt + 1'b1;
    end
  end

  // Result stage: the box fields only move when the frame met MIN_PIXELS, so a
  // weak frame republishes the previous box alongside its own count.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      resXmin    <= '0;
      resXmax    <= '0;
      resYmin    <= '0;
      resYmax    <= '0;
      resXcenter <= '0;
      resYcenter <= '0;
      resCnt     <= '0;
      resValid   <= 1'b0;
    end else if (latchRes) begin
      resCnt   <= pixCnt;
      resValid <= boxOk;
      if (boxOk) begin
        resXmin    <= xMinRun;
        resXmax    <= xMaxRun;
        resYmin    <= yMinRun;
        resYmax    <= yMaxRun;
        resXcenter <= 9'(xSum >> 1);
        resYcenter <= 8'(ySum >> 1);
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oNewCoord <= 1'b0;
      oBoxValid <= 1'b0;
      oXmin     <= '0;
      oXmax     <= '0;
      oYmin     <= '0;
      oYmax     <= '0;
      oXcenter  <= '0;
      oYcenter  <= '0;
      oPixCount <= '0;
    end else if (publish) begin
      oNewCoord <= 1'b1;
      oBoxValid <= resValid;
      oXmin     <= resXmin;
      oXmax     <= resXmax;
      oYmin     <= resYmin;
      oYmax     <= resYmax;
      oXcenter  <= resXcenter;
      oYcenter  <= resYcenter;
      oPixCount <= resCnt;
    end else if (accept) begin
      oNewCoord <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blob_box_controller.sv
// Directed self-checking bench for blob_box_controller: frame sequences with
// hand-computed boxes, checked with immediate assertions.
module tb_blob_box_controller;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iFrameStart, iFrameEnd, iPixelValid, iMotion, iReady;
  logic [8:0]  iX;
  logic [7:0]  iY;
  logic        oNewCoord, oBoxValid;
  logic [8:0]  oXmin, oXmax, oXcenter;
  logic [7:0]  oYmin, oYmax, oYcenter;
  logic [16:0] oPixCount;

  int checks = 0;
  int errors = 0;

  blob_box_controller dut (
    .iClock(iClock), .iReset(iReset), .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
    .iPixelValid(iPixelValid), .iMotion(iMotion), .iX(iX), .iY(iY), .iReady(iReady),
    .oNewCoord(oNewCoord), .oBoxValid(oBoxValid), .oXmin(oXmin), .oXmax(oXmax),
    .oYmin(oYmin), .oYmax(oYmax), .oXcenter(oXcenter), .oYcenter(oYcenter),
    .oPixCount(oPixCount)
  );

  always #5 iClock = ~iClock;

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input int nc, input int bv, input int xmin,
                        input int xmax, input int ymin, input int ymax, input int xc,
                        input int yc, input int cnt);
    chk({tag, ".newCoord"}, int'(oNewCoord), nc);
    chk({tag, ".boxValid"}, int'(oBoxValid), bv);
    chk({tag, ".xmin"}, int'(oXmin), xmin);
    chk({tag, ".xmax"}, int'(oXmax), xmax);
    chk({tag, ".ymin"}, int'(oYmin), ymin);
    chk({tag, ".ymax"}, int'(oYmax), ymax);
    chk({tag, ".xcenter"}, int'(oXcenter), xc);
    chk({tag, ".ycenter"}, int'(oYcenter), yc);
    chk({tag, ".count"}, int'(oPixCount), cnt);
  endtask

  task automatic pix(input int x, input int y, input bit m);
    iPixelValid = 1'b1;
    iMotion     = m;
    iX          = 9'(x);
    iY          = 8'(y);
    step();
    iPixelValid = 1'b0;
    iMotion     = 1'b0;
  endtask

  task automatic frameStart();
    iFrameStart = 1'b1;
    step();
    iFrameStart = 1'b0;
  endtask

  // Pulses iFrameEnd at edge N; returns just after edge N+2 with oNewCoord checked high.
  task automatic frameEnd(input string tag);
    iFrameEnd = 1'b1;
    step();
    iFrameEnd = 1'b0;
    chk({tag, ".lat0"}, int'(oNewCoord), 0);
    step();
    chk({tag, ".lat1"}, int'(oNewCoord), 0);
    step();
    chk({tag, ".lat2"}, int'(oNewCoord), 1);
  endtask

  initial begin
    iReset = 1'b0; iFrameStart = 1'b0; iFrameEnd = 1'b0; iPixelValid = 1'b0;
    iMotion = 1'b0; iReady = 1'b1; iX = '0; iY = '0;
    #1;
    chkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    iReset = 1'b1;
    step();

    // Basic 16-pixel horizontal run
    frameStart();
    for (int i = 0; i < 16; i++) pix(40 + i, 30, 1'b1);
    frameEnd("t1");
    chkAll("t1", 1, 1, 40, 55, 30, 30, 47, 30, 16);
    step();
    chk("t1.pulseEnd", int'(oNewCoord), 0);

    // Weak frame: box holds, valid drops
    frameStart();
    for (int i = 0; i < 5; i++) pix(1 + i, 1, 1'b1);
    frameEnd("t2");
    chkAll("t2", 1, 0, 40, 55, 30, 30, 47, 30, 5);
    step();
    chk("t2.pulseEnd", int'(oNewCoord), 0);

    // Corners plus out-of-range and non-motion pixels
    frameStart();
    pix(0, 0, 1'b1);
    pix(320, 10, 1'b1);
    pix(10, 240, 1'b1);
    pix(5, 5, 1'b0);
    for (int i = 0; i < 18; i++) pix(100 + i, 100, 1'b1);
    pix(319, 239, 1'b1);
    frameEnd("t3");
    chkAll("t3", 1, 1, 0, 319, 0, 239, 159, 119, 20);
    step();
    chk("t3.pulseEnd", int'(oNewCoord), 0);

    // Backpressure with an overlapped frame
    iReady = 1'b0;
    frameStart();
    for (int i = 0; i < 16; i++) pix(10 + i, 20, 1'b1);
    frameEnd("t4");
    chkAll("t4", 1, 1, 10, 25, 20, 20, 17, 20, 16);
    for (int c = 0; c < 10; c++) begin
      iFrameStart = (c == 0);
      iFrameEnd   = (c == 9);
      iPixelValid = (c >= 1 && c <= 8);
      iMotion     = 1'b1;
      iX          = 9'd200;
      iY          = 8'd200;
      step();
      chk("t4.holdNc", int'(oNewCoord), 1);
      chk("t4.holdXmin", int'(oXmin), 10);
      chk("t4.holdCnt", int'(oPixCount), 16);
    end
    iFrameStart = 1'b0; iFrameEnd = 1'b0; iPixelValid = 1'b0; iMotion = 1'b0;
    iReady = 1'b1;
    step();
    chk("t4.accept", int'(oNewCoord), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4.noOverlapResult", int'(oNewCoord), 0);
    end

    // Restart mid-frame
    frameStart();
    for (int i = 0; i < 8; i++) pix(100, 100, 1'b1);
    frameStart();
    for (int i = 0; i < 16; i++) pix(200 + i, 50, 1'b1);
    frameEnd("t5a");
    chkAll("t5a", 1, 1, 200, 215, 50, 50, 207, 50, 16);
    step();

    // Start together with end terminates; pixel on the end cycle counts
    frameStart();
    for (int i = 0; i < 15; i++) pix(60 + i, 70, 1'b1);
    iFrameStart = 1'b1; iPixelValid = 1'b1; iMotion = 1'b1; iX = 9'd75; iY = 8'd70;
    frameEnd("t5b");
    iFrameStart = 1'b0; iPixelValid = 1'b0; iMotion = 1'b0;
    chkAll("t5b", 1, 1, 60, 75, 70, 70, 67, 70, 16);
    step();
    chk("t5b.pulseEnd", int'(oNewCoord), 0);

    // Reset during ACCUM
    frameStart();
    for (int i = 0; i < 4; i++) pix(30 + i, 30, 1'b1);
    iReset = 1'b0;
    #1;
    chkAll("t6a", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    iReset = 1'b1;
    iFrameEnd = 1'b1;
    step();
    iFrameEnd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6a.noPulse", int'(oNewCoord), 0);
    end

    // Reset during OUTPUT
    iReady = 1'b0;
    frameStart();
    for (int i = 0; i < 16; i++) pix(80 + i, 90, 1'b1);
    frameEnd("t6b");
    iReset = 1'b0;
    #1;
    chkAll("t6b", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    iReset = 1'b1;
    iReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6b.noPulse", int'(oNewCoord), 0);
      chk("t6b.count", int'(oPixCount), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
